// File: rtl/mem_read_ctrl_if.sv
// mem_read_ctrl_if
//   Memory read bus between the load-path controller and the memory/bus unit.
//
//   Handshake: the master raises mem_stb with a word-aligned mem_addr and holds
//   both constant until it samples mem_ack high on a rising edge. mem_ack
//   qualifies mem_din in that same cycle; there is no separate data phase.
//   mem_ack while mem_stb is low carries no meaning and is ignored.
//
//   Signals:
//     mem_addr  32  word-aligned read address     (master -> slave)
//     mem_stb    1  read strobe                   (master -> slave)
//     mem_ack    1  acknowledge, mem_din valid    (slave  -> master)
//     mem_din   32  read data                     (slave  -> master)
interface mem_read_ctrl_if;
    logic [31:0] mem_addr;
    logic        mem_stb;
    logic        mem_ack;
    logic [31:0] mem_din;

    modport master (output mem_addr, output mem_stb, input mem_ack, input mem_din);
    modport slave  (input mem_addr, input mem_stb, output mem_ack, output mem_din);
endinterface

// File: rtl/mem_read_ctrl.sv
// mem_read_ctrl
//   Load-path controller. Accepts a load request, issues a word-aligned read
//   on the memory bus, latches the returned word into the MDR and presents
//   both the raw MDR with its byte position and an aligned, sign/zero
//   extended load result.
//
//   Optional feature (macro MRC_TIMEOUT_EN): a REQ-state cycle counter that
//   aborts the access to FAIL after TIMEOUT cycles without mem_ack.
//
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     start      load request (sampled only in IDLE)
//     addr       byte address of the load
//     size       00 byte, 01 half, 10 word, 11 reserved
//     sign_ext   1 = sign-extend byte/half, 0 = zero-extend
//     busy       high in every state except IDLE
//     done       one-cycle completion pulse
//     err        with done: misaligned, reserved size or timeout
//     data_out   aligned and extended load result
//     mdr_out    raw latched MDR word
//     pos_out    latched addr[1:0] for the byte-select stage
//     bus        memory read bus (master side)
//     state_dbg  current FSM state encoding
module mem_read_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      addr,
    input  logic [1:0]       size,
    input  logic             sign_ext,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      data_out,
    output logic [31:0]      mdr_out,
    output logic [1:0]       pos_out,
    mem_read_ctrl_if.master  bus,
    output logic [1:0]       state_dbg
);

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("mem_read_ctrl: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        FAIL = 2'd3
    } state_t;

    state_t      state_q, state_n;
    logic        busy_q, busy_n, done_q, done_n, err_q, err_n;
    logic        stb_q, stb_n;
    logic [31:0] maddr_q, maddr_n;
    logic [31:0] mdr_q, mdr_n;
    logic [31:0] data_q, data_n;
    logic [1:0]  pos_q, pos_n;
    // Request attributes captured at acceptance; used when the word returns.
    logic [1:0]  lat_pos_q, lat_pos_n;
    logic [1:0]  lat_size_q, lat_size_n;
    logic        lat_sext_q, lat_sext_n;
    logic        illegal;

`ifdef MRC_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_n;
`endif

    // Byte lane is picked by the low address bits; halfword by pos[1] only.
    function automatic logic [31:0] align_load(input logic [31:0] w,
                                               input logic [1:0]  pos,
                                               input logic [1:0]  sz,
                                               input logic        sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{pos, 3'b000} +: 8];
        h = pos[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = {{24{sx & b[7]}}, b};
            2'b01:   r = {{16{sx & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        illegal = (size == 2'b11) ||
                  (size == 2'b01 && addr[0]) ||
                  (size == 2'b10 && addr[1:0] != 2'b00);
    end

    always_comb begin
        state_n    = state_q;
        stb_n      = stb_q;
        maddr_n    = maddr_q;
        mdr_n      = mdr_q;
        pos_n      = pos_q;
        data_n     = data_q;
        lat_pos_n  = lat_pos_q;
        lat_size_n = lat_size_q;
        lat_sext_n = lat_sext_q;
`ifdef MRC_TIMEOUT_EN
        cnt_n      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    lat_pos_n  = addr[1:0];
                    lat_size_n = size;
                    lat_sext_n = sign_ext;
                    if (illegal) begin
                        state_n = FAIL;
                        data_n  = '0;
                    end else begin
                        state_n = REQ;
                        stb_n   = 1'b1;
                        maddr_n = {addr[31:2], 2'b00};
`ifdef MRC_TIMEOUT_EN
                        cnt_n   = '0;
`endif
                    end
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    mdr_n   = bus.mem_din;
                    pos_n   = lat_pos_q;
                    data_n  = align_load(bus.mem_din, lat_pos_q, lat_size_q, lat_sext_q);
                    stb_n   = 1'b0;
                    state_n = DONE;
                end
`ifdef MRC_TIMEOUT_EN
                // Expiry only applies when no ack arrives in the same cycle.
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    stb_n   = 1'b0;
                    data_n  = '0;
                    state_n = FAIL;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
`endif
            end
            DONE:    state_n = IDLE;
            FAIL:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE) || (state_n == FAIL);
        err_n  = (state_n == FAIL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            stb_q      <= 1'b0;
            maddr_q    <= '0;
            mdr_q      <= '0;
            pos_q      <= '0;
            data_q     <= '0;
            lat_pos_q  <= '0;
            lat_size_q <= '0;
            lat_sext_q <= 1'b0;
`ifdef MRC_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            err_q      <= err_n;
            stb_q      <= stb_n;
            maddr_q    <= maddr_n;
            mdr_q      <= mdr_n;
            pos_q      <= pos_n;
            data_q     <= data_n;
            lat_pos_q  <= lat_pos_n;
            lat_size_q <= lat_size_n;
            lat_sext_q <= lat_sext_n;
`ifdef MRC_TIMEOUT_EN
            cnt_q      <= cnt_n;
`endif
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign data_out     = data_q;
    assign mdr_out      = mdr_q;
    assign pos_out      = pos_q;
    assign bus.mem_stb  = stb_q;
    assign bus.mem_addr = maddr_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_mem_read_ctrl.sv
// tb_mem_read_ctrl
//   Directed bench for mem_read_ctrl. Inputs are driven and outputs sampled on
//   the falling clock edge. Build with +define+MRC_TIMEOUT_EN to exercise the
//   timeout path with TIMEOUT = 4.
module tb_mem_read_ctrl;

`ifdef MRC_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 16;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sign_ext;
    logic        busy, done, err;
    logic [31:0] data_out, mdr_out;
    logic [1:0]  pos_out;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    mem_read_ctrl_if bus ();

    mem_read_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .addr      (addr),
        .size      (size),
        .sign_ext  (sign_ext),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .data_out  (data_out),
        .mdr_out   (mdr_out),
        .pos_out   (pos_out),
        .bus       (bus.master),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    logic [31:0] last_mdr = '0;
    logic [1:0]  last_pos = '0;

    always @(posedge clk) begin
        if (bus.mem_stb && bus.mem_ack) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    // Successful load: ack after dly idle strobe cycles, then checks results.
    task automatic load_ok(input string tag, input logic [31:0] a, input logic [1:0] sz,
                           input logic sx, input int dly, input logic [31:0] din,
                           input logic [31:0] exp_data);
        int n0;
        n0 = acc_cnt;
        start = 1'b1; addr = a; size = sz; sign_ext = sx;
        step();
        start = 1'b0;
        check({tag, "_stb"},   {31'd0, bus.mem_stb}, 32'd1);
        check({tag, "_maddr"}, bus.mem_addr, {a[31:2], 2'b00});
        check({tag, "_busy"},  {31'd0, busy}, 32'd1);
        for (int i = 0; i < dly; i++) begin
            step();
            check({tag, "_stb_hold"},   {31'd0, bus.mem_stb}, 32'd1);
            check({tag, "_maddr_hold"}, bus.mem_addr, {a[31:2], 2'b00});
            check({tag, "_no_done"},    {31'd0, done}, 32'd0);
        end
        bus.mem_ack = 1'b1; bus.mem_din = din;
        step();
        bus.mem_ack = 1'b0; bus.mem_din = 32'hDEAD_BEEF;
        check({tag, "_done"},   {31'd0, done}, 32'd1);
        check({tag, "_err"},    {31'd0, err}, 32'd0);
        check({tag, "_data"},   data_out, exp_data);
        check({tag, "_mdr"},    mdr_out, din);
        check({tag, "_pos"},    {30'd0, pos_out}, {30'd0, a[1:0]});
        check({tag, "_stb_lo"}, {31'd0, bus.mem_stb}, 32'd0);
        check({tag, "_acc"},    acc_cnt - n0, 32'd1);
        step();
        check({tag, "_done_lo"},  {31'd0, done}, 32'd0);
        check({tag, "_idle"},     {31'd0, busy}, 32'd0);
        check({tag, "_data_hold"}, data_out, exp_data);
        last_mdr = din;
        last_pos = a[1:0];
    endtask

    // Illegal request: FAIL next cycle with no bus access.
    task automatic load_fail(input string tag, input logic [31:0] a, input logic [1:0] sz);
        start = 1'b1; addr = a; size = sz; sign_ext = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_no_stb"}, {31'd0, bus.mem_stb}, 32'd0);
        check({tag, "_done"},   {31'd0, done}, 32'd1);
        check({tag, "_err"},    {31'd0, err}, 32'd1);
        check({tag, "_data0"},  data_out, 32'd0);
        check({tag, "_mdr"},    mdr_out, last_mdr);
        check({tag, "_pos"},    {30'd0, pos_out}, {30'd0, last_pos});
        step();
        check({tag, "_done_lo"}, {31'd0, done}, 32'd0);
        check({tag, "_err_lo"},  {31'd0, err}, 32'd0);
        check({tag, "_idle"},    {31'd0, busy}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n0;
        rst = 1'b1; start = 1'b0; addr = '0; size = '0; sign_ext = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_din = '0;
        step();
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_stb",   {31'd0, bus.mem_stb}, 32'd0);
        check("rst_maddr", bus.mem_addr, 32'd0);
        check("rst_data",  data_out, 32'd0);
        check("rst_mdr",   mdr_out, 32'd0);
        check("rst_pos",   {30'd0, pos_out}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        rst = 1'b0;
        step();

        // Directed loads with hand-computed results.
        load_ok("b3_sx",  32'h0000_1003, 2'b00, 1'b1, 3, 32'h80FF_1234, 32'hFFFF_FF80);
        load_ok("h2_zx",  32'h0000_2002, 2'b01, 1'b0, 0, 32'h9ABC_5678, 32'h0000_9ABC);
        load_ok("b1_zx",  32'h0000_1001, 2'b00, 1'b0, 1, 32'h80FF_1234, 32'h0000_0012);
        load_ok("b2_sx",  32'h0000_1002, 2'b00, 1'b1, 0, 32'h80FF_1234, 32'hFFFF_FFFF);
        load_ok("b0_pos", 32'h0000_1000, 2'b00, 1'b1, 0, 32'h0000_007F, 32'h0000_007F);
        load_ok("h0_sx",  32'h0000_2000, 2'b01, 1'b1, 2, 32'h9ABC_8678, 32'hFFFF_8678);
        load_ok("w_full", 32'h0000_4000, 2'b10, 1'b1, 0, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Illegal requests.
        load_fail("w_mis",  32'h0000_3001, 2'b10);
        load_fail("rsv_sz", 32'h0000_3000, 2'b11);
        load_fail("h_odd",  32'h0000_3003, 2'b01);
        load_fail("w_mis2", 32'h0000_3002, 2'b10);

        // start held high through REQ and the done cycle: one access only.
        n0 = acc_cnt;
        start = 1'b1; addr = 32'h0000_5000; size = 2'b10; sign_ext = 1'b0;
        step();
        addr = 32'h0000_6000;
        for (int i = 0; i < 2; i++) begin
            check("sb_busy",  {31'd0, busy}, 32'd1);
            check("sb_maddr", bus.mem_addr, 32'h0000_5000);
            step();
        end
        bus.mem_ack = 1'b1; bus.mem_din = 32'h1122_3344;
        step();
        bus.mem_ack = 1'b0;
        check("sb_done", {31'd0, done}, 32'd1);
        check("sb_data", data_out, 32'h1122_3344);
        step();
        start = 1'b0;
        check("sb_idle",   {31'd0, busy}, 32'd0);
        check("sb_no_stb", {31'd0, bus.mem_stb}, 32'd0);
        check("sb_acc",    acc_cnt - n0, 32'd1);
        step();
        check("sb_still_idle", {31'd0, busy}, 32'd0);
        last_mdr = 32'h1122_3344;
        last_pos = 2'd0;

        // Reset in the middle of REQ.
        start = 1'b1; addr = 32'h0000_7000; size = 2'b10; sign_ext = 1'b0;
        step();
        start = 1'b0;
        check("mr_stb", {31'd0, bus.mem_stb}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mr_stb_drop",  {31'd0, bus.mem_stb}, 32'd0);
        check("mr_busy_drop", {31'd0, busy}, 32'd0);
        check("mr_state",     {30'd0, state_dbg}, 32'd0);
        step();
        rst = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_din = 32'h5555_AAAA;
        step();
        bus.mem_ack = 1'b0;
        check("mr_no_done", {31'd0, done}, 32'd0);
        check("mr_mdr",     mdr_out, 32'd0);
        check("mr_busy",    {31'd0, busy}, 32'd0);
        step();
        check("mr_no_done2", {31'd0, done}, 32'd0);
        last_mdr = '0;
        last_pos = '0;

`ifdef MRC_TIMEOUT_EN
        // No ack: FAIL after 4 REQ cycles.
        start = 1'b1; addr = 32'h0000_8000; size = 2'b10; sign_ext = 1'b0;
        step();
        start = 1'b0;
        check("to_stb", {31'd0, bus.mem_stb}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("to_stb_hold", {31'd0, bus.mem_stb}, 32'd1);
            check("to_no_done",  {31'd0, done}, 32'd0);
        end
        step();
        check("to_stb_lo", {31'd0, bus.mem_stb}, 32'd0);
        check("to_done",   {31'd0, done}, 32'd1);
        check("to_err",    {31'd0, err}, 32'd1);
        check("to_data0",  data_out, 32'd0);
        check("to_mdr",    mdr_out, last_mdr);
        step();
        check("to_idle", {31'd0, busy}, 32'd0);
        // Ack in the 4th REQ cycle wins over expiry.
        load_ok("to_ack", 32'h0000_8004, 2'b10, 1'b0, 3, 32'h1234_5678, 32'h1234_5678);
`else
        // Without the timeout the strobe waits as long as needed.
        load_ok("long_wait", 32'h0000_8006, 2'b01, 1'b1, 20, 32'h8001_0203, 32'hFFFF_8001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_read_ctrl.md
Name: mem_read_ctrl

Overview:
- Load-path controller that produces the memory data register (MDR) contents and the byte position for the load datapath.
- Accepts a load request from the CPU control unit, issues a word-aligned read on the memory bus and waits for the acknowledge.
- Latches the returned word into the MDR, then presents both the raw MDR plus byte position and a fully aligned, sign- or zero-extended load result.
- Sits between the CPU control FSM and the memory/bus interface, directly upstream of the byte-select stage.

Parameters:
- TIMEOUT, 16, number of cycles in REQ without mem_ack before the access aborts (used only with MRC_TIMEOUT_EN); minimum 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  load request; sampled only in IDLE.
- addr  input  32  byte address of the load.
- size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- sign_ext  input  1  1 = sign-extend byte/half, 0 = zero-extend.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 = misaligned, reserved size or timeout.
- data_out  output  32  aligned and extended load result.
- mdr_out  output  32  raw latched MDR word.
- pos_out  output  2  latched addr[1:0] for the byte-select stage.
- mem_addr  output  32  word-aligned bus address {addr[31:2],2'b00}.
- mem_stb  output  1  bus read strobe.
- mem_ack  input  1  bus acknowledge; mem_din is valid in the same cycle.
- mem_din  input  32  bus read data.

Behaviour:
- Reset (asynchronous, takes effect immediately): state = IDLE; busy, done, err, mem_stb = 0; data_out, mdr_out, mem_addr = 0; pos_out = 0. A reset during REQ drops mem_stb at once and abandons the access.
- States: IDLE, REQ, DONE, FAIL. All outputs are registered.
- IDLE:
  - On start, latch addr, size and sign_ext.
  - If the request is legal, go to REQ with mem_stb = 1 and mem_addr = word-aligned address.
  - Illegal requests go to FAIL with no bus access: size 01 with addr[0] = 1; size 10 with addr[1:0] != 0; size 11.
- REQ:
  - mem_stb and mem_addr are held constant until mem_ack.
  - On mem_ack: mdr_out <= mem_din, pos_out <= addr[1:0], mem_stb <= 0, state -> DONE.
- DONE: done = 1, err = 0 for exactly one cycle; data_out is valid; then IDLE.
- data_out:
  - byte: select MDR[8*pos+7 : 8*pos], extend bit 7.
  - half: pos[1] selects MDR[31:16] or MDR[15:0], extend bit 15.
  - word: full MDR.
  - Extension uses sign_ext; zero-extension fills the upper bits with 0.
- FAIL: done = 1, err = 1, data_out = 0 for one cycle; mdr_out and pos_out are unchanged; then IDLE.
- Latency: start accepted at edge N gives mem_stb high from N. An ack in cycle N+k (k ≥ 0 after stb is high) gives done in cycle N+k+1. Minimum start-to-done is 2 cycles; a FAIL completes in 1 cycle.
- start while busy is ignored and not queued. start arriving in the same cycle as done is ignored; a new request is accepted from IDLE on the following cycle.
- mem_ack outside REQ is ignored.
- data_out, mdr_out and pos_out hold their values until the next successful completion.

Optional Feature:
- MRC_TIMEOUT_EN defined: a counter clears on entry to REQ and increments every REQ cycle without mem_ack. When the count reaches TIMEOUT, mem_stb drops and the state goes to FAIL (done = 1, err = 1). An ack in the expiry cycle wins, and the access completes normally.
- MRC_TIMEOUT_EN not defined: no counter exists, and REQ waits for mem_ack indefinitely.

Test Plan:
- Byte load, sign_ext = 1: addr 0x1003, mem_din 0x80FF_1234 with ack 3 cycles after stb. Expect mem_addr = 0x1000, data_out = 0xFFFF_FF80, mdr_out = 0x80FF_1234, pos_out = 3, done 1 cycle after ack.
- Half load, sign_ext = 0: addr 0x2002, mem_din 0x9ABC_5678 with ack in the first stb cycle. Expect data_out = 0x0000_9ABC, start-to-done = 2 cycles.
- Misaligned: word at addr 0x3001. Expect no mem_stb, FAIL with done = 1, err = 1, data_out = 0 in the next cycle. Repeat with size 11 and expect the same response.
- start pulsed repeatedly during REQ and in the done cycle: expect a single bus access only, with busy = 1 until done.
- Reset asserted mid-REQ: mem_stb and busy drop asynchronously, and no done is produced. A later ack is ignored.
- With MRC_TIMEOUT_EN and TIMEOUT = 4, give no ack: expect mem_stb low and done/err after 4 REQ cycles. A second run with ack in the 4th cycle must complete with err = 0.
